// File: rtl/sha256_msg_sched.sv
// Packs a 32-bit big-endian word stream into 512-bit blocks, applies SHA-256 padding and runs sha256_core one block at a time.
// Optional cycle counter on cycles_o is built when SHA256_SCHED_CYCLE_CNT_EN is defined.
module sha256_msg_sched #(
  parameter int BlockWidth  = 512,
  parameter int DigestWidth = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   msg_valid_i,
  output logic                   msg_ready_o,
  input  logic [31:0]            msg_data_i,
  input  logic                   msg_last_i,
  input  logic [2:0]             msg_bytes_i,
  input  logic                   abort_i,
  input  logic                   clear_i,
  output logic [BlockWidth-1:0]  block_o,
  output logic                   enable_hash_o,
  output logic                   rst_hash_o,
  input  logic                   hold_i,
  input  logic                   idle_i,
  input  logic [DigestWidth-1:0] core_digest_i,
  input  logic                   core_valid_i,
  output logic [DigestWidth-1:0] digest_o,
  output logic                   digest_valid_o,
  output logic                   busy_o,
  output logic [31:0]            cycles_o
);

  typedef enum logic [2:0] {IDLE, FILL, PAD, ISSUE, WAIT, DONE} state_e;

  state_e            state_q, state_d;
  logic [15:0][31:0] buf_q;
  logic [3:0]        widx_q;
  logic [63:0]       len_q;
  logic              mark_pend_q, pad_more_q, len_ok_q, rst_pulse_q;
  logic              accept;
  logic [2:0]        nbytes;
  logic [31:0]       word_in, pad_word;
  logic [63:0]       len_bits;

  assign accept   = msg_valid_i & msg_ready_o & ~abort_i;
  assign nbytes   = (msg_bytes_i > 3'd4) ? 3'd4 : msg_bytes_i;
  assign len_bits = len_q << 3;
  assign block_o  = buf_q;

  // Last word: keep the valid bytes, drop the 0x80 marker right after them.
  always_comb begin
    word_in = msg_data_i;
    if (msg_last_i) begin
      case (nbytes)
        3'd0:    word_in = 32'h8000_0000;
        3'd1:    word_in = {msg_data_i[31:24], 24'h80_0000};
        3'd2:    word_in = {msg_data_i[31:16], 16'h8000};
        3'd3:    word_in = {msg_data_i[31:8], 8'h80};
        default: word_in = msg_data_i;
      endcase
    end
  end

  // len_ok_q: the marker sits early enough in this block for the length to follow.
  always_comb begin
    pad_word = 32'h0;
    if (mark_pend_q)                       pad_word = 32'h8000_0000;
    else if (len_ok_q && widx_q == 4'd14) pad_word = len_bits[63:32];
    else if (len_ok_q && widx_q == 4'd15) pad_word = len_bits[31:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, FILL: if (accept) begin
        if (widx_q == 4'd15)  state_d = ISSUE;
        else if (msg_last_i)  state_d = PAD;
        else                  state_d = FILL;
      end
      PAD:   if (widx_q == 4'd15) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (core_valid_i) state_d = DONE;
        else if (hold_i)  state_d = pad_more_q ? PAD : FILL;
      end
      DONE:    if (clear_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i) state_d = IDLE;
  end

  always_comb begin
    msg_ready_o    = 1'b0;
    enable_hash_o  = 1'b0;
    rst_hash_o     = rst_pulse_q;
    busy_o         = 1'b1;
    digest_valid_o = 1'b0;
    case (state_q)
      IDLE:  begin msg_ready_o = idle_i; rst_hash_o = rst_pulse_q | ~idle_i; busy_o = 1'b0; end
      FILL:  msg_ready_o = 1'b1;
      ISSUE: enable_hash_o = 1'b1;
      WAIT:  enable_hash_o = ~hold_i;
      DONE:  begin digest_valid_o = 1'b1; busy_o = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q <= '0; widx_q <= '0; len_q <= '0; digest_o <= '0;
      mark_pend_q <= 1'b0; pad_more_q <= 1'b0; len_ok_q <= 1'b0; rst_pulse_q <= 1'b0;
    end else if (abort_i || (state_q == DONE && clear_i)) begin
      buf_q <= '0; widx_q <= '0; len_q <= '0;
      mark_pend_q <= 1'b0; pad_more_q <= 1'b0; len_ok_q <= 1'b0; rst_pulse_q <= 1'b1;
    end else begin
      rst_pulse_q <= 1'b0;
      case (state_q)
        IDLE, FILL: if (accept) begin
          buf_q[4'd15 - widx_q] <= word_in;
          widx_q <= widx_q + 4'd1;
          len_q  <= len_q + (msg_last_i ? 64'(nbytes) : 64'd4);
          if (msg_last_i) begin
            mark_pend_q <= (nbytes == 3'd4);
            if (nbytes != 3'd4) len_ok_q <= (widx_q <= 4'd13);
            if (widx_q == 4'd15) pad_more_q <= 1'b1;
          end
        end
        PAD: begin
          buf_q[4'd15 - widx_q] <= pad_word;
          widx_q <= widx_q + 4'd1;
          if (mark_pend_q) begin
            mark_pend_q <= 1'b0;
            len_ok_q    <= (widx_q <= 4'd13);
          end
          if (widx_q == 4'd15) pad_more_q <= mark_pend_q | ~len_ok_q;
        end
        ISSUE: widx_q <= '0;
        WAIT: begin
          if (core_valid_i) digest_o <= core_digest_i;
          else if (hold_i) begin
            buf_q <= '0;
            if (pad_more_q) begin
              pad_more_q <= 1'b0;
              len_ok_q   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SHA256_SCHED_CYCLE_CNT_EN
  logic [31:0] cyc_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                      cyc_q <= '0;
    else if (abort_i || (state_q == DONE && clear_i)) cyc_q <= '0;
    else if (state_q == IDLE && accept)               cyc_q <= 32'd1;
    else if (busy_o && cyc_q != 32'hFFFF_FFFF)        cyc_q <= cyc_q + 32'd1;
  end
  assign cycles_o = cyc_q;
`else
  assign cycles_o = 32'h0;
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched with a behavioural SHA-256 core model attached.
module tb_sha256_msg_sched;

  localparam int CORE_LAT = 20;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  logic         clk, rst_n;
  logic         msg_valid, msg_ready, msg_last, abort, clear;
  logic [31:0]  msg_data, cycles;
  logic [2:0]   msg_bytes;
  logic [511:0] block;
  logic         enable_hash, rst_hash, hold, core_idle, cvalid, digest_valid, busy;
  logic [255:0] core_h, digest;

  sha256_msg_sched dut (
    .clk_i(clk), .rst_ni(rst_n),
    .msg_valid_i(msg_valid), .msg_ready_o(msg_ready), .msg_data_i(msg_data),
    .msg_last_i(msg_last), .msg_bytes_i(msg_bytes), .abort_i(abort), .clear_i(clear),
    .block_o(block), .enable_hash_o(enable_hash), .rst_hash_o(rst_hash),
    .hold_i(hold), .idle_i(core_idle), .core_digest_i(core_h), .core_valid_i(cvalid),
    .digest_o(digest), .digest_valid_o(digest_valid), .busy_o(busy), .cycles_o(cycles));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_blk(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7] +
             (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  function automatic logic [31:0] wd(input logic [511:0] blk, input int n);
    return blk[511 - 32*n -: 32];
  endfunction

  function automatic logic [31:0] seqw(input int i);
    return {8'(4*i), 8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3)};
  endfunction

  // Core model: a block loads on enable while idle; after CORE_LAT cycles it pulses
  // hold (more blocks expected) or digest valid (n_blocks reached).
  int           n_blocks;
  int           issue_cnt, lat, viol;
  logic [511:0] cap [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_idle <= 1'b1; hold <= 1'b0; cvalid <= 1'b0; core_h <= IV; lat <= 0; issue_cnt <= 0;
    end else begin
      hold <= 1'b0; cvalid <= 1'b0;
      if (rst_hash) begin
        core_idle <= 1'b1; core_h <= IV; lat <= 0; issue_cnt <= 0;
      end else if (core_idle && enable_hash) begin
        core_idle <= 1'b0;
        cap[issue_cnt[1:0]] <= block;
        issue_cnt <= issue_cnt + 1;
        core_h <= sha_blk(core_h, block);
        lat <= CORE_LAT;
      end else if (lat > 1) lat <= lat - 1;
      else if (lat == 1) begin
        lat <= 0;
        if (issue_cnt >= n_blocks) cvalid <= 1'b1;
        else begin hold <= 1'b1; core_idle <= 1'b1; end
      end
    end
  end

  initial viol = 0;
  always @(negedge clk) if (hold && enable_hash) viol = viol + 1;

  int tests, fails;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic last, input logic [2:0] b);
    int n = 0;
    msg_valid = 1'b1; msg_data = d; msg_last = last; msg_bytes = b;
    while (!msg_ready && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) chk("send_timeout", 256'(n), 256'(0));
    @(negedge clk);
    msg_valid = 1'b0; msg_last = 1'b0; msg_bytes = 3'd0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!digest_valid && n < 3000) begin @(negedge clk); n++; end
    chk(tag, 256'(digest_valid), 256'(1));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_dv_drop", 256'(digest_valid), 256'(0));
    chk("clr_rst_pulse", 256'(rst_hash), 256'(1));
    @(negedge clk);
    chk("clr_rst_end", 256'(rst_hash), 256'(0));
    chk("clr_ready", 256'(msg_ready), 256'(1));
  endtask

  logic [511:0] e0, e1;
  logic [31:0]  cyc_snap;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0; n_blocks = 1;
    rst_n = 1'b0; msg_valid = 1'b0; msg_data = '0; msg_last = 1'b0; msg_bytes = '0;
    abort = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_enable", 256'(enable_hash), 256'(0));
    chk("rst_dvalid", 256'(digest_valid), 256'(0));
    chk("rst_digest", digest, 256'(0));
    chk("rst_cycles", 256'(cycles), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_block", 256'(block[511:256] | block[255:0]), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 256'(msg_ready), 256'(1));
    chk("rst_rsthash", 256'(rst_hash), 256'(0));

    // Empty message
    n_blocks = 1;
    send(32'h0, 1'b1, 3'd0);
    chk("empty_busy", 256'(busy), 256'(1));
    wait_done("empty_done");
    chk("empty_w0", 256'(wd(cap[0], 0)), 256'(32'h8000_0000));
    chk("empty_w15", 256'(wd(cap[0], 15)), 256'(0));
    chk("empty_digest", digest, 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);
    chk("done_ready", 256'(msg_ready), 256'(0));
    chk("done_busy", 256'(busy), 256'(0));
    do_clear();

    // "abc"
    send(32'h6162_6300, 1'b1, 3'd3);
    wait_done("abc_done");
    chk("abc_w0", 256'(wd(cap[0], 0)), 256'(32'h6162_6380));
    chk("abc_w15", 256'(wd(cap[0], 15)), 256'(32'h18));
    chk("abc_digest", digest, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
    cyc_snap = cycles;
`ifdef SHA256_SCHED_CYCLE_CNT_EN
    chk("abc_cyc_nz", 256'(cycles != 32'h0), 256'(1));
`else
    chk("abc_cyc_zero", 256'(cycles), 256'(0));
`endif
    repeat (5) @(negedge clk);
    chk("abc_cyc_stable", 256'(cycles), 256'(cyc_snap));
    chk("abc_dv_level", 256'(digest_valid), 256'(1));
    do_clear();

    // 56-byte message: length spills into a second block
    n_blocks = 2;
    for (int i = 0; i < 14; i++)
      send({8'(8'h61 + i), 8'(8'h62 + i), 8'(8'h63 + i), 8'(8'h64 + i)}, i == 13, 3'd4);
    wait_done("m56_done");
    chk("m56_issues", 256'(issue_cnt), 256'(2));
    chk("m56_b0w13", 256'(wd(cap[0], 13)), 256'(32'h6e6f_7071));
    chk("m56_b0w14", 256'(wd(cap[0], 14)), 256'(32'h8000_0000));
    chk("m56_b0w15", 256'(wd(cap[0], 15)), 256'(0));
    chk("m56_b1w0", 256'(wd(cap[1], 0)), 256'(0));
    chk("m56_b1w15", 256'(wd(cap[1], 15)), 256'(32'h1c0));
    chk("m56_digest", digest, 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);
    do_clear();

    // 64-byte message ending on a full final word
    n_blocks = 2;
    for (int i = 0; i < 16; i++) send(seqw(i), i == 15, 3'd4);
    wait_done("m64_done");
    e0 = '0; e1 = '0;
    for (int i = 0; i < 16; i++) e0[511 - 32*i -: 32] = seqw(i);
    e1[511 -: 32] = 32'h8000_0000; e1[31:0] = 32'h200;
    chk("m64_b1w0", 256'(wd(cap[1], 0)), 256'(32'h8000_0000));
    chk("m64_b1w15", 256'(wd(cap[1], 15)), 256'(32'h200));
    chk("m64_digest", digest, sha_blk(sha_blk(IV, e0), e1));
    do_clear();

    // 78 bytes; word 16 is held valid through ISSUE/WAIT of block 0
    n_blocks = 2;
    for (int i = 0; i < 20; i++) send(seqw(i), i == 19, (i == 19) ? 3'd2 : 3'd4);
    wait_done("m78_done");
    e1 = '0;
    for (int i = 0; i < 3; i++) e1[511 - 32*i -: 32] = seqw(16 + i);
    e1[511 - 96 -: 32] = {seqw(19) >> 16, 16'h8000};
    e1[31:0] = 32'h270;
    chk("m78_b1", cap[1][511:256] ^ e1[511:256] | cap[1][255:0] ^ e1[255:0], 256'(0));
    chk("m78_digest", digest, sha_blk(sha_blk(IV, e0), e1));
    do_clear();

    // Abort in WAIT, then a fresh "abc"
    n_blocks = 3;
    for (int i = 0; i < 16; i++) send(seqw(i), 1'b0, 3'd4);
    repeat (4) @(negedge clk);
    chk("abt_core_busy", 256'(core_idle), 256'(0));
    abort = 1'b1;
    msg_valid = 1'b1; msg_data = 32'hdead_beef;
    @(negedge clk);
    abort = 1'b0; msg_valid = 1'b0;
    chk("abt_rst_pulse", 256'(rst_hash), 256'(1));
    chk("abt_busy", 256'(busy), 256'(0));
    chk("abt_cycles", 256'(cycles), 256'(0));
    @(negedge clk);
    chk("abt_core_idle", 256'(core_idle), 256'(1));
    chk("abt_ready", 256'(msg_ready), 256'(1));
    n_blocks = 1;
    send(32'h6162_6300, 1'b1, 3'd3);
    wait_done("abt_abc_done");
    chk("abt_abc_w0", 256'(wd(cap[0], 0)), 256'(32'h6162_6380));
    chk("abt_abc_digest", digest, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abt_done_dv", 256'(digest_valid), 256'(0));
    chk("hold_enable_overlap", 256'(viol), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
